// File: rtl/lock_detect_if.sv
// -----------------------------------------------------------------------------
// lock_detect_if
//
// Purpose: carries period measurements from the period counter into the lock
// detector.
//
// Handshake: period_valid is a one-cycle strobe that qualifies
// period_length_1000 in the same cycle. There is no ready signal, so the
// consumer accepts every strobe. Strobes may arrive on consecutive cycles.
//
// Signals:
//   period_valid        strobe, 1 = period_length_1000 holds a new measurement
//   period_length_1000  measured period in 1/1000 ns, unsigned; 0 = no clock
//
// Modports:
//   master  drives the measurement (period counter / testbench)
//   slave   receives the measurement (lock_detect)
// -----------------------------------------------------------------------------
interface lock_detect_if;
  logic        period_valid;
  logic [31:0] period_length_1000;

  modport master (
    output period_valid,
    output period_length_1000
  );

  modport slave (
    input period_valid,
    input period_length_1000
  );
endinterface

// File: rtl/lock_detect.sv
// -----------------------------------------------------------------------------
// lock_detect
//
// Purpose: period-stability lock detector. Each strobed period measurement is
// compared with the previously accepted one. After LOCK_COUNT consecutive
// in-tolerance measurements LOCKED rises and the period is latched as the
// reference. While locked, every measurement is compared with that reference
// so slow drift is caught. UNLOCK_COUNT consecutive misses, a zero
// measurement or power-down drop the lock.
//
// Parameters:
//   LOCK_COUNT      consecutive matching samples needed to lock (2..255)
//   UNLOCK_COUNT    consecutive misses while locked that drop lock (1..255)
//   TOLERANCE_1000  largest |difference| counted as a match, 1/1000 ns
//
// Ports:
//   clk              sole clock, rising edge
//   RST              synchronous active-high reset, highest priority
//   PWRDWN           synchronous power-down; drops lock, ignores samples
//   bus              measurement input (period_valid / period_length_1000)
//   LOCKED           registered lock indication
//   ref_period_1000  period latched at lock acquisition; holds across loss
//   lock_lost        one-cycle pulse on every LOCKED 1->0 not caused by RST
//   state            0 IDLE, 1 ACQUIRE, 2 LOCKED (3 never driven)
// -----------------------------------------------------------------------------
module lock_detect #(
  parameter int unsigned LOCK_COUNT     = 8,
  parameter int unsigned UNLOCK_COUNT   = 2,
  parameter int unsigned TOLERANCE_1000 = 100
) (
  input  logic               clk,
  input  logic               RST,
  input  logic               PWRDWN,
  lock_detect_if.slave       bus,
  output logic               LOCKED,
  output logic [31:0]        ref_period_1000,
  output logic               lock_lost,
  output logic [1:0]         state
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_LOCKED  = 2'd2
  } state_t;

  localparam logic [7:0]  LOCK_CNT_8   = 8'(LOCK_COUNT);
  localparam logic [7:0]  UNLOCK_CNT_8 = 8'(UNLOCK_COUNT);
  localparam logic [31:0] TOL_32       = 32'(TOLERANCE_1000);

  state_t      state_q;
  logic [31:0] prev_q;
  logic [7:0]  match_cnt_q;
  logic [7:0]  miss_cnt_q;
  logic        locked_q;
  logic [31:0] ref_q;
  logic        lock_lost_q;

  // Comparison datapath. While locked the sample is judged against the
  // latched reference rather than the previous sample, so that a sequence of
  // small steps cannot walk the period away without being noticed.
  logic [31:0] sample;
  logic [31:0] cmp_base;
  logic [31:0] diff;
  logic        sample_zero;
  logic        is_match;
  logic [7:0]  match_cnt_inc;
  logic [7:0]  miss_cnt_inc;
  logic        accept;

  always_comb begin
    sample        = bus.period_length_1000;
    cmp_base      = (state_q == ST_LOCKED) ? ref_q : prev_q;
    // Subtract the smaller from the larger so the magnitude never wraps.
    diff          = (sample >= cmp_base) ? (sample - cmp_base)
                                         : (cmp_base - sample);
    sample_zero   = (sample == 32'd0);
    is_match      = (diff <= TOL_32) && !sample_zero;
    match_cnt_inc = match_cnt_q + 8'd1;
    miss_cnt_inc  = miss_cnt_q + 8'd1;
    accept        = bus.period_valid;
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      prev_q      <= 32'd0;
      match_cnt_q <= 8'd0;
      miss_cnt_q  <= 8'd0;
      locked_q    <= 1'b0;
      ref_q       <= 32'd0;
      lock_lost_q <= 1'b0;
    end else begin
      // lock_lost is a pulse: it only stays high for the cycle after the
      // edge that dropped the lock.
      lock_lost_q <= 1'b0;

      if (PWRDWN) begin
        // Samples arriving during power-down are dropped. The reference is
        // kept so software can still read the last locked period.
        state_q     <= ST_IDLE;
        match_cnt_q <= 8'd0;
        miss_cnt_q  <= 8'd0;
        locked_q    <= 1'b0;
        lock_lost_q <= locked_q;
      end else if (accept) begin
        unique case (state_q)
          ST_IDLE: begin
            if (!sample_zero) begin
              prev_q      <= sample;
              match_cnt_q <= 8'd1;
              state_q     <= ST_ACQUIRE;
            end
          end

          ST_ACQUIRE: begin
            if (sample_zero) begin
              state_q     <= ST_IDLE;
              match_cnt_q <= 8'd0;
              miss_cnt_q  <= 8'd0;
            end else if (is_match) begin
              prev_q      <= sample;
              match_cnt_q <= match_cnt_inc;
              if (match_cnt_inc == LOCK_CNT_8) begin
                state_q    <= ST_LOCKED;
                ref_q      <= sample;
                locked_q   <= 1'b1;
                miss_cnt_q <= 8'd0;
              end
            end else begin
              // The mismatching sample becomes the first of a new run.
              prev_q      <= sample;
              match_cnt_q <= 8'd1;
            end
          end

          ST_LOCKED: begin
            if (sample_zero) begin
              // Loss of clock drops lock at once, whatever the miss count.
              state_q     <= ST_IDLE;
              match_cnt_q <= 8'd0;
              miss_cnt_q  <= 8'd0;
              locked_q    <= 1'b0;
              lock_lost_q <= 1'b1;
            end else if (is_match) begin
              miss_cnt_q <= 8'd0;
            end else begin
              miss_cnt_q <= miss_cnt_inc;
              if (miss_cnt_inc == UNLOCK_CNT_8) begin
                // Re-acquire starting from the sample that broke the lock.
                state_q     <= ST_ACQUIRE;
                prev_q      <= sample;
                match_cnt_q <= 8'd1;
                miss_cnt_q  <= 8'd0;
                locked_q    <= 1'b0;
                lock_lost_q <= 1'b1;
              end
            end
          end

          default: begin
            state_q     <= ST_IDLE;
            match_cnt_q <= 8'd0;
            miss_cnt_q  <= 8'd0;
            locked_q    <= 1'b0;
          end
        endcase
      end
    end
  end

  assign LOCKED          = locked_q;
  assign ref_period_1000 = ref_q;
  assign lock_lost       = lock_lost_q;
  assign state           = state_q;

endmodule

// File: tb/tb_lock_detect.sv
// -----------------------------------------------------------------------------
// tb_lock_detect
//
// Directed scenarios followed by randomized traffic. A behavioural model of
// the lock rules (run of accepted samples kept as a queue, distance computed
// with wide signed arithmetic) predicts state/lock_lost/LOCKED/reference after
// every clock edge; predictions go through an expected queue and are compared
// 1 ns after the edge.
// -----------------------------------------------------------------------------
module tb_lock_detect;
  localparam int LOCK   = 8;
  localparam int UNLOCK = 2;
  localparam int TOL    = 100;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        RST;
  logic        PWRDWN;
  logic        LOCKED;
  logic [31:0] ref_period_1000;
  logic        lock_lost;
  logic [1:0]  state;

  lock_detect_if bus ();

  lock_detect #(
    .LOCK_COUNT     (LOCK),
    .UNLOCK_COUNT   (UNLOCK),
    .TOLERANCE_1000 (TOL)
  ) dut (
    .clk             (clk),
    .RST             (RST),
    .PWRDWN          (PWRDWN),
    .bus             (bus),
    .LOCKED          (LOCKED),
    .ref_period_1000 (ref_period_1000),
    .lock_lost       (lock_lost),
    .state           (state)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [35:0] exp_q[$];   // {state, lock_lost, LOCKED, ref_period_1000}

  // ---------------- reference model ----------------
  int          m_mode;      // 0 idle, 1 acquiring, 2 locked
  logic [31:0] m_run_q[$];  // samples of the current matching run
  int          m_misses;
  logic [31:0] m_ref;
  bit          m_locked;
  bit          m_lost;

  function automatic bit close_to(input logic [31:0] s, input logic [31:0] base);
    longint a;
    longint b;
    longint d;
    a = s;
    b = base;
    d = a - b;
    if (d < 0) d = -d;
    return (d <= TOL) && (s != 32'd0);
  endfunction

  task automatic model_step(input bit r, input bit p, input bit v,
                            input logic [31:0] s);
    if (r) begin
      m_mode = 0; m_run_q.delete(); m_misses = 0;
      m_ref = '0; m_locked = 0; m_lost = 0;
    end else begin
      m_lost = 0;
      if (p) begin
        m_lost = m_locked;
        m_mode = 0; m_locked = 0; m_run_q.delete(); m_misses = 0;
      end else if (v) begin
        if (m_mode == 0) begin
          if (s != 0) begin
            m_run_q.delete(); m_run_q.push_back(s); m_mode = 1;
          end
        end else if (m_mode == 1) begin
          if (s == 0) begin
            m_mode = 0; m_run_q.delete(); m_misses = 0;
          end else if (close_to(s, m_run_q[$])) begin
            m_run_q.push_back(s);
            if (m_run_q.size() == LOCK) begin
              m_mode = 2; m_locked = 1; m_ref = s; m_misses = 0;
            end
          end else begin
            m_run_q.delete(); m_run_q.push_back(s);
          end
        end else begin
          if (s == 0) begin
            m_mode = 0; m_locked = 0; m_lost = 1;
            m_run_q.delete(); m_misses = 0;
          end else if (close_to(s, m_ref)) begin
            m_misses = 0;
          end else begin
            m_misses++;
            if (m_misses == UNLOCK) begin
              m_mode = 1; m_locked = 0; m_lost = 1; m_misses = 0;
              m_run_q.delete(); m_run_q.push_back(s);
            end
          end
        end
      end
    end
  endtask

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // ---------------- driver ----------------
  task automatic step(input bit r, input bit p, input bit v,
                      input logic [31:0] s);
    logic [35:0] e;
    RST                    = r;
    PWRDWN                 = p;
    bus.period_valid       = v;
    bus.period_length_1000 = s;
    @(posedge clk);
    model_step(r, p, v, s);
    exp_q.push_back({2'(m_mode), m_lost, m_locked, m_ref});
    #1;
    e = exp_q.pop_front();
    check("model_state",  32'(state),     32'(e[35:34]));
    check("model_lost",   32'(lock_lost), 32'(e[33]));
    check("model_locked", 32'(LOCKED),    32'(e[32]));
    check("model_ref",    ref_period_1000, e[31:0]);
  endtask

  task automatic strobes(input int n, input logic [31:0] s);
    for (int i = 0; i < n; i++) step(0, 0, 1, s);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] base;
    logic [31:0] smp;
    bit r, p, v;

    RST = 1'b1; PWRDWN = 1'b0;
    bus.period_valid = 1'b0; bus.period_length_1000 = '0;

    // Reset state
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    check("rst_locked", 32'(LOCKED), 0);
    check("rst_ref", ref_period_1000, 0);
    check("rst_state", 32'(state), 0);

    // Lock acquisition: 8 strobes of 10000
    strobes(7, 32'd10000);
    check("acq7_locked", 32'(LOCKED), 0);
    step(0, 0, 1, 32'd10000);
    check("acq8_locked", 32'(LOCKED), 1);
    check("acq8_ref", ref_period_1000, 32'd10000);
    check("acq8_state", 32'(state), 2);
    check("acq8_lost", 32'(lock_lost), 0);

    // Drift: 10050 matches the reference, two 10150 misses unlock
    step(0, 0, 1, 32'd10050);
    step(0, 0, 1, 32'd10150);
    check("miss1_locked", 32'(LOCKED), 1);
    step(0, 0, 1, 32'd10150);
    check("miss2_locked", 32'(LOCKED), 0);
    check("miss2_lost", 32'(lock_lost), 1);
    check("miss2_state", 32'(state), 1);
    step(0, 0, 0, 0);
    check("miss2_lost_pulse", 32'(lock_lost), 0);

    // Relock at 10150, isolated misses separated by a match keep lock
    strobes(7, 32'd10150);
    check("relock_ref", ref_period_1000, 32'd10150);
    step(0, 0, 1, 32'd10300);
    step(0, 0, 1, 32'd10150);
    step(0, 0, 1, 32'd10300);
    check("isolated_locked", 32'(LOCKED), 1);

    // Zero sample drops lock at once, reference holds
    step(0, 0, 1, 32'd0);
    check("zero_state", 32'(state), 0);
    check("zero_lost", 32'(lock_lost), 1);
    check("zero_ref", ref_period_1000, 32'd10150);

    // Power-down while locked, with a strobe in the same cycle
    strobes(8, 32'd10000);
    step(0, 1, 1, 32'd10000);
    check("pd_state", 32'(state), 0);
    check("pd_lost", 32'(lock_lost), 1);
    check("pd_ref", ref_period_1000, 32'd10000);
    strobes(0, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 1, 32'd12345);
    check("pd_strobes_state", 32'(state), 0);
    check("pd_strobes_lost", 32'(lock_lost), 0);
    step(0, 0, 0, 0);

    // Tolerance edge: steps of exactly 100 all match
    for (int i = 0; i < 8; i++) step(0, 0, 1, 32'(10000 + 100 * i));
    check("ramp_locked", 32'(LOCKED), 1);
    check("ramp_ref", ref_period_1000, 32'd10700);

    // Step of 101 restarts the run
    step(1, 0, 0, 0);
    step(0, 0, 1, 32'd10000);
    step(0, 0, 1, 32'd10100);
    step(0, 0, 1, 32'd10201);
    strobes(6, 32'd10201);
    check("step101_9_locked", 32'(LOCKED), 0);
    step(0, 0, 1, 32'd10201);
    check("step101_10_locked", 32'(LOCKED), 1);

    // Reset while locked gives no lock_lost
    step(1, 0, 0, 0);
    check("rst_locked_lost", 32'(lock_lost), 0);
    check("rst_locked_locked", 32'(LOCKED), 0);

    // Reset mid-acquire after 5 matches, with PWRDWN and a strobe present
    strobes(5, 32'd10000);
    step(1, 1, 1, 32'd10000);
    check("rstacq_state", 32'(state), 0);
    check("rstacq_ref", ref_period_1000, 0);
    check("rstacq_lost", 32'(lock_lost), 0);
    strobes(7, 32'd10000);
    check("rstacq_7_locked", 32'(LOCKED), 0);
    step(0, 0, 1, 32'd10000);
    check("rstacq_8_locked", 32'(LOCKED), 1);

    // Back-to-back strobes of 25000 from idle
    step(1, 0, 0, 0);
    strobes(7, 32'd25000);
    check("b2b_cycle8_locked", 32'(LOCKED), 0);
    step(0, 0, 1, 32'd25000);
    check("b2b_cycle9_locked", 32'(LOCKED), 1);
    check("b2b_ref", ref_period_1000, 32'd25000);

    // Extreme values: 0xFFFFFFFF followed by 1 must not look close
    step(1, 0, 0, 0);
    step(0, 0, 1, 32'hFFFF_FFFF);
    strobes(7, 32'd1);
    check("wrap_locked", 32'(LOCKED), 0);
    step(0, 0, 1, 32'd1);
    check("wrap_relock", 32'(LOCKED), 1);
    check("wrap_ref", ref_period_1000, 32'd1);

    // Randomized traffic around a slowly moving base period
    step(1, 0, 0, 0);
    base = 32'(20000);
    for (int i = 0; i < 1500; i++) begin
      r = ($urandom_range(0, 299) == 0);
      p = ($urandom_range(0, 79) == 0);
      v = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 59) == 0) base = 32'($urandom_range(5000, 60000));
      if ($urandom_range(0, 49) == 0) smp = 32'd0;
      else if ($urandom_range(0, 3) == 0)
        smp = base + 32'($urandom_range(0, 300)) - 32'd150;
      else
        smp = base + 32'($urandom_range(0, 60)) - 32'd30;
      step(r, p, v, smp);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
